// File: rtl/pipeline_pkg.sv
// Shared types for the hazard controller: forward codes, pipeline slot record,
// FSM states and the inst_type bit positions.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] writenum;
    logic       is_ldr;
  } slot_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  localparam int INST_LDR = 0;
  localparam int INST_STR = 1;

  localparam slot_t SLOT_EMPTY = '0;

  // A slot only produces a hazard when it holds a real register write.
  function automatic logic slot_hit(input slot_t s, input logic [2:0] num);
    return s.valid & s.write & (s.writenum == num);
  endfunction

endpackage

// File: rtl/pipeline_fwd_match.sv
// One source operand compared against EX/MEM/WB; youngest matching slot wins.
// Purely combinational, zero latency, no flow control.
module pipeline_fwd_match
  import pipeline_pkg::*;
(
  input  logic       used,
  input  logic [2:0] num,
  input  slot_t      ex_slot,
  input  slot_t      mem_slot,
  input  slot_t      wb_slot,
  output fwd_sel_e   fwd,
  output logic       ldr_hit
);

  always_comb begin
    fwd = FWD_RF;
    if (used) begin
      if (slot_hit(ex_slot, num))       fwd = FWD_EX;
      else if (slot_hit(mem_slot, num)) fwd = FWD_MEM;
      else if (slot_hit(wb_slot, num))  fwd = FWD_WB;
    end
  end

  assign ldr_hit = used & slot_hit(ex_slot, num) & ex_slot.is_ldr;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Tracks EX/MEM/WB destinations, selects operand forwarding, inserts load-use bubbles.
// stall/issue/fwd are same-cycle combinational; mem_busy freezes every slot.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic       dec_write,
  input  logic [2:0] dec_writenum,
  input  logic [2:0] num_Rm,
  input  logic [2:0] num_Rn,
  input  logic [2:0] num_Rd,
  input  logic [2:0] used_RmRnRd,
  input  logic [5:0] inst_type,
  input  logic       mem_busy,
  output logic       stall,
  output logic       issue,
  output logic [1:0] fwd_Rm,
  output logic [1:0] fwd_Rn,
  output logic [1:0] fwd_Rd,
  output logic [7:0] busy_regs,
  output logic [7:0] stall_cnt
);

  slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  state_e     state_q, state_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  fwd_sel_e   fwd_m, fwd_n, fwd_d;
  logic [2:0] ldr_hit;
  logic       load_use;
  logic       unused_inst_bits;

  assign unused_inst_bits = ^inst_type[5:INST_STR];

  pipeline_fwd_match u_match_rm (
    .used(used_RmRnRd[2]), .num(num_Rm), .ex_slot(ex_q), .mem_slot(mem_q),
    .wb_slot(wb_q), .fwd(fwd_m), .ldr_hit(ldr_hit[2])
  );
  pipeline_fwd_match u_match_rn (
    .used(used_RmRnRd[1]), .num(num_Rn), .ex_slot(ex_q), .mem_slot(mem_q),
    .wb_slot(wb_q), .fwd(fwd_n), .ldr_hit(ldr_hit[1])
  );
  pipeline_fwd_match u_match_rd (
    .used(used_RmRnRd[0]), .num(num_Rd), .ex_slot(ex_q), .mem_slot(mem_q),
    .wb_slot(wb_q), .fwd(fwd_d), .ldr_hit(ldr_hit[0])
  );

  assign fwd_Rm    = fwd_m;
  assign fwd_Rn    = fwd_n;
  assign fwd_Rd    = fwd_d;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    load_use    = dec_valid & (|ldr_hit);
    stall       = mem_busy | load_use;
    issue       = dec_valid & ~stall;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;

    if (stall && (stall_cnt_q != 8'hFF)) stall_cnt_d = stall_cnt_q + 8'd1;

    if (!mem_busy) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = issue ? slot_t'{1'b1, dec_write, dec_writenum, inst_type[INST_LDR]}
                    : SLOT_EMPTY;
    end

    // Load-use is re-evaluated on the release cycle of a memory wait.
    unique case (state_q)
      RUN:      state_d = load_use ? LU_STALL : RUN;
      LU_STALL: state_d = RUN;
      MEM_WAIT: state_d = load_use ? LU_STALL : RUN;
      default:  state_d = RUN;
    endcase
    if (mem_busy) state_d = MEM_WAIT;
  end

  always_comb begin
    busy_regs = 8'h00;
    if (ex_q.valid  & ex_q.write)  busy_regs[ex_q.writenum]  = 1'b1;
    if (mem_q.valid & mem_q.write) busy_regs[mem_q.writenum] = 1'b1;
    if (wb_q.valid  & wb_q.write)  busy_regs[wb_q.writenum]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= SLOT_EMPTY;
      mem_q       <= SLOT_EMPTY;
      wb_q        <= SLOT_EMPTY;
      state_q     <= RUN;
      stall_cnt_q <= 8'h00;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a slot-list model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dec_valid, dec_write, mem_busy;
  logic [2:0] dec_writenum, num_Rm, num_Rn, num_Rd, used_RmRnRd;
  logic [5:0] inst_type;
  logic       stall, issue;
  logic [1:0] fwd_Rm, fwd_Rn, fwd_Rd;
  logic [7:0] busy_regs, stall_cnt;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_write(dec_write),
    .dec_writenum(dec_writenum), .num_Rm(num_Rm), .num_Rn(num_Rn), .num_Rd(num_Rd),
    .used_RmRnRd(used_RmRnRd), .inst_type(inst_type), .mem_busy(mem_busy),
    .stall(stall), .issue(issue), .fwd_Rm(fwd_Rm), .fwd_Rn(fwd_Rn), .fwd_Rd(fwd_Rd),
    .busy_regs(busy_regs), .stall_cnt(stall_cnt)
  );

  // Model: pipe[0] is the youngest in-flight instruction (EX), pipe[2] the oldest (WB).
  typedef struct {
    bit       v;
    bit       w;
    bit       l;
    bit [2:0] n;
  } mslot_t;
  mslot_t pipe [3];
  int     m_cnt;

  function automatic bit hits(input int i, input logic [2:0] num);
    return pipe[i].v && pipe[i].w && (pipe[i].n == num);
  endfunction

  function automatic logic [1:0] m_fwd(input logic used, input logic [2:0] num);
    if (!used) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (hits(i, num)) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic bit m_stall();
    bit lu = 1'b0;
    if (dec_valid && pipe[0].l) begin
      if (used_RmRnRd[2] && hits(0, num_Rm)) lu = 1'b1;
      if (used_RmRnRd[1] && hits(0, num_Rn)) lu = 1'b1;
      if (used_RmRnRd[0] && hits(0, num_Rd)) lu = 1'b1;
    end
    return mem_busy || lu;
  endfunction

  function automatic logic [7:0] m_busy();
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 3; i++)
      if (pipe[i].v && pipe[i].w) b[pipe[i].n] = 1'b1;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state update.
  initial begin
    bit st;
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    m_cnt = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        m_cnt = 0;
      end else begin
        st = m_stall();
        if (st && m_cnt < 255) m_cnt++;
        if (!mem_busy) begin
          pipe[2] = pipe[1];
          pipe[1] = pipe[0];
          if (dec_valid && !st)
            pipe[0] = '{v: 1'b1, w: dec_write, l: inst_type[0], n: dec_writenum};
          else
            pipe[0] = '{default: 0};
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cmp_en) begin
        chk("m_stall", 8'(stall), 8'(m_stall()));
        chk("m_issue", 8'(issue), 8'(dec_valid && !m_stall()));
        chk("m_fwd_Rm", 8'(fwd_Rm), 8'(m_fwd(used_RmRnRd[2], num_Rm)));
        chk("m_fwd_Rn", 8'(fwd_Rn), 8'(m_fwd(used_RmRnRd[1], num_Rn)));
        chk("m_fwd_Rd", 8'(fwd_Rd), 8'(m_fwd(used_RmRnRd[0], num_Rd)));
        chk("m_busy_regs", busy_regs, m_busy());
        chk("m_stall_cnt", stall_cnt, 8'(m_cnt));
      end
    end
  end

  task automatic drv(input logic v, input logic w, input logic [2:0] wn,
                     input logic [2:0] rm, input logic [2:0] rn, input logic [2:0] rd,
                     input logic [2:0] u, input logic [5:0] it);
    dec_valid = v; dec_write = w; dec_writenum = wn;
    num_Rm = rm; num_Rn = rn; num_Rd = rd; used_RmRnRd = u; inst_type = it;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    bit hold;
    mem_busy = 1'b0;
    drv(1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 3'd2, 3'b111, 6'b000001);
    #2;
    chk("rst_stall", 8'(stall), 8'd0);
    chk("rst_issue", 8'(issue), 8'd1);
    chk("rst_busy", busy_regs, 8'h00);
    chk("rst_fwd_Rm", 8'(fwd_Rm), 8'd0);
    chk("rst_cnt", stall_cnt, 8'd0);
    chk("rst_state", 8'(dut.state_q), 8'(RUN));
    @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    // ADD R2 then reader of R2 forwards from EX.
    drv(1'b1, 1'b1, 3'd2, 3'd0, 3'd0, 3'd0, 3'b000, 6'd0);
    step();
    drv(1'b1, 1'b1, 3'd4, 3'd2, 3'd0, 3'd0, 3'b100, 6'd0);
    @(negedge clk);
    chk("add_fwd_Rm", 8'(fwd_Rm), 8'd1);
    chk("add_stall", 8'(stall), 8'd0);
    chk("add_issue", 8'(issue), 8'd1);
    chk("add_busy", busy_regs, 8'h04);
    step();

    // LDR R3 then MOV reading R3: one bubble, then MEM forward.
    drv(1'b1, 1'b1, 3'd3, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000001);
    step();
    drv(1'b1, 1'b1, 3'd4, 3'd3, 3'd0, 3'd0, 3'b100, 6'd0);
    @(negedge clk);
    chk("lu_stall", 8'(stall), 8'd1);
    chk("lu_issue", 8'(issue), 8'd0);
    step();
    @(negedge clk);
    chk("lu_after_stall", 8'(stall), 8'd0);
    chk("lu_after_issue", 8'(issue), 8'd1);
    chk("lu_fwd_Rm", 8'(fwd_Rm), 8'd2);
    chk("lu_cnt", stall_cnt, 8'd1);
    step();

    // MVN R5, CMP (no write, dest 6), STR reading Rd=R5, then reader of R6.
    drv(1'b1, 1'b1, 3'd5, 3'd0, 3'd0, 3'd0, 3'b000, 6'd0);
    step();
    drv(1'b1, 1'b0, 3'd6, 3'd1, 3'd2, 3'd0, 3'b110, 6'd0);
    step();
    drv(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd5, 3'b001, 6'b000010);
    @(negedge clk);
    chk("str_fwd_Rd", 8'(fwd_Rd), 8'd2);
    step();
    drv(1'b1, 1'b1, 3'd7, 3'd0, 3'd6, 3'd0, 3'b010, 6'd0);
    @(negedge clk);
    chk("cmp_fwd_Rn", 8'(fwd_Rn), 8'd0);
    chk("cmp_stall", 8'(stall), 8'd0);
    step();

    // R1 in EX and WB: youngest wins.
    drv(1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 3'd0, 3'b000, 6'd0);
    step();
    drv(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 6'd0);
    step();
    drv(1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 3'd0, 3'b000, 6'd0);
    step();
    drv(1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 3'b100, 6'd0);
    @(negedge clk);
    chk("young_fwd_Rm", 8'(fwd_Rm), 8'd1);
    chk("young_busy", busy_regs, 8'h02);

    // mem_busy for 3 cycles coincident with load-use.
    do_reset();
    drv(1'b1, 1'b1, 3'd3, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000001);
    step();
    drv(1'b1, 1'b1, 3'd4, 3'd3, 3'd0, 3'd0, 3'b100, 6'd0);
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mw_stall", 8'(stall), 8'd1);
      chk("mw_issue", 8'(issue), 8'd0);
      chk("mw_busy", busy_regs, 8'h08);
      if (k > 0) chk("mw_state", 8'(dut.state_q), 8'(MEM_WAIT));
      step();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("mw_rel_stall", 8'(stall), 8'd1);
    chk("mw_rel_busy", busy_regs, 8'h08);
    step();
    @(negedge clk);
    chk("mw_done_stall", 8'(stall), 8'd0);
    chk("mw_done_fwd_Rm", 8'(fwd_Rm), 8'd2);
    chk("mw_done_cnt", stall_cnt, 8'd4);
    step();

    // Reset while in LU_STALL.
    drv(1'b1, 1'b1, 3'd3, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000001);
    step();
    drv(1'b1, 1'b1, 3'd4, 3'd3, 3'd0, 3'd0, 3'b100, 6'd0);
    @(negedge clk);
    chk("rs_pre_stall", 8'(stall), 8'd1);
    step();
    @(negedge clk);
    chk("rs_state_lu", 8'(dut.state_q), 8'(LU_STALL));
    #1 reset = 1'b1;
    #1;
    chk("rs_busy", busy_regs, 8'h00);
    chk("rs_stall", 8'(stall), 8'd0);
    chk("rs_issue", 8'(issue), 8'd1);
    chk("rs_cnt", stall_cnt, 8'd0);
    chk("rs_state", 8'(dut.state_q), 8'(RUN));
    #1 reset = 1'b0;
    step();
    @(negedge clk);
    chk("rs_after_fwd_Rm", 8'(fwd_Rm), 8'd0);
    chk("rs_after_busy", busy_regs, 8'h10);

    // Randomized traffic; a stalled instruction is held as the decoder would.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hold = m_stall();
      @(posedge clk);
      #1;
      if (!hold) begin
        dec_valid    = ($urandom_range(0, 9) < 8);
        dec_write    = ($urandom_range(0, 9) < 7);
        dec_writenum = 3'($urandom_range(0, 3));
        num_Rm       = 3'($urandom_range(0, 3));
        num_Rn       = 3'($urandom_range(0, 3));
        num_Rd       = 3'($urandom_range(0, 3));
        used_RmRnRd  = 3'($urandom_range(0, 7));
        inst_type    = {5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 3)};
      end
      mem_busy = ($urandom_range(0, 99) < 15);
    end

    // Long memory wait drives the counter into saturation.
    mem_busy = 1'b1;
    repeat (260) step();
    @(negedge clk);
    chk("sat_cnt", stall_cnt, 8'hFF);
    chk("sat_stall", 8'(stall), 8'd1);
    mem_busy = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
